tile_addr_seq: RTL and testbench

// - Parametrised successor of the single-unit A/B read-address generator for the systolic tensor core.
// - Walks a programmable M-tile x N-tile x K-word loop nest and emits paired SRAM read addresses for

---
 rtl/tile_addr_seq_pkg.sv | 21 ++
 rtl/tile_addr_seq_if.sv | 15 +
 rtl/tile_addr_seq_loop_ctr.sv | 20 ++
 rtl/tile_addr_seq.sv | 125 ++++++++++++
 tb/tb_tile_addr_seq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tile_addr_seq_pkg.sv
// tile_addr_seq_pkg: shared types, default widths and packing helper for the tile address sequencer
package tile_addr_seq_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_TILE_W = 8;
   localparam int DEF_KLEN_W = 12;
   typedef enum logic [1:0] {FP32, FP16, INT8, INT4} dtype_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
   typedef struct packed {
      dtype_t                dtype;
      logic [DEF_ADDR_W-1:0] base_a;
      logic [DEF_ADDR_W-1:0] base_b;
      logic [DEF_ADDR_W-1:0] str_a;
      logic [DEF_ADDR_W-1:0] str_b;
      logic [DEF_TILE_W-1:0] m;
      logic [DEF_TILE_W-1:0] n;
      logic [DEF_KLEN_W-1:0] k;
   } addrgen_cfg_t;
   function automatic logic [1:0] pack_shift(dtype_t dt);
      return dt == FP32 ? 2'd0 : dt == FP16 ? 2'd1 : dt == INT8 ? 2'd2 : 2'd3;
   endfunction
endpackage

// File: rtl/tile_addr_seq_if.sv
// tile_addr_seq_if: operand read-address beat channel between the sequencer and the SRAM read ports
interface tile_addr_seq_if
   import tile_addr_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) ();
   logic              addr_valid;
   logic              addr_ready;
   logic              first_k;
   logic              last_k;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   modport master (output addr_valid, addr_a, addr_b, first_k, last_k, input addr_ready);
   modport slave (input addr_valid, addr_a, addr_b, first_k, last_k, output addr_ready);
endinterface

// File: rtl/tile_addr_seq_loop_ctr.sv
// tile_addr_seq_loop_ctr: loop counter with synchronous clear, enable and wrap at a programmable limit
module tile_addr_seq_loop_ctr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] lim_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign wrap_o = cnt_q == lim_i;
   assign cnt_o  = cnt_q;
   always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : wrap_o ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/tile_addr_seq.sv
// tile_addr_seq: walks an M-tile x N-tile x K-word nest emitting paired A/B operand read addresses
module tile_addr_seq
   import tile_addr_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int TILE_W = DEF_TILE_W,
   parameter int KLEN_W = DEF_KLEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  dtype_t            cfg_dtype_i,
   input  logic [ADDR_W-1:0] cfg_base_a_i,
   input  logic [ADDR_W-1:0] cfg_base_b_i,
   input  logic [ADDR_W-1:0] cfg_str_a_i,
   input  logic [ADDR_W-1:0] cfg_str_b_i,
   input  logic [TILE_W-1:0] cfg_m_i,
   input  logic [TILE_W-1:0] cfg_n_i,
   input  logic [KLEN_W-1:0] cfg_k_i,
   output logic              busy_o,
   output logic              done_o,
   tile_addr_seq_if.master   bus
);
   seq_state_t        state_q;
   logic [ADDR_W-1:0] base_b_q, str_a_q, str_b_q, row_a_q, row_b_q, addr_a_q, addr_b_q;
   logic [ADDR_W-1:0] row_a_d, row_b_d;
   logic [TILE_W-1:0] m_lim_q, n_lim_q, nt_unused, mt_unused;
   logic [KLEN_W-1:0] kw_lim_q, kw_lim_d, k_cnt, k_nxt;
   logic [KLEN_W:0]   k_sum;
   logic [1:0]        sh;
   logic              valid_q, first_q, last_q, busy_q, done_q;
   logic              go, accept, acc_nt, acc_mt, final_beat, k_wrap, nt_wrap, mt_wrap;

   assign bus.addr_valid = valid_q;
   assign bus.addr_a     = addr_a_q;
   assign bus.addr_b     = addr_b_q;
   assign bus.first_k    = first_q;
   assign bus.last_k     = last_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;

   // KW = ceil(k/PACK) by adding PACK-1 before the shift; k==0 counts as one element
   always_comb begin
      go         = state_q == IDLE && start_i;
      accept     = state_q == RUN && valid_q && bus.addr_ready && !abort_i;
      acc_nt     = accept && k_wrap;
      acc_mt     = acc_nt && nt_wrap;
      final_beat = acc_mt && mt_wrap;
      sh         = pack_shift(cfg_dtype_i);
      k_sum      = (cfg_k_i == '0 ? (KLEN_W+1)'(1) : {1'b0, cfg_k_i}) + (KLEN_W+1)'((32'd1 << sh) - 32'd1);
      kw_lim_d   = KLEN_W'((k_sum >> sh) - 1'b1);
      k_nxt      = k_wrap ? '0 : k_cnt + 1'b1;
      row_b_d    = !k_wrap ? row_b_q : nt_wrap ? base_b_q : row_b_q + str_b_q;
      row_a_d    = k_wrap && nt_wrap ? row_a_q + str_a_q : row_a_q;
   end

   tile_addr_seq_loop_ctr #(.W(KLEN_W)) u_k (
      .clk(clk), .rst(rst), .clr_i(go), .en_i(accept), .lim_i(kw_lim_q), .cnt_o(k_cnt), .wrap_o(k_wrap)
   );
   tile_addr_seq_loop_ctr #(.W(TILE_W)) u_nt (
      .clk(clk), .rst(rst), .clr_i(go), .en_i(acc_nt), .lim_i(n_lim_q), .cnt_o(nt_unused), .wrap_o(nt_wrap)
   );
   tile_addr_seq_loop_ctr #(.W(TILE_W)) u_mt (
      .clk(clk), .rst(rst), .clr_i(go), .en_i(acc_mt), .lim_i(m_lim_q), .cnt_o(mt_unused), .wrap_o(mt_wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         base_b_q <= '0;
         str_a_q  <= '0;
         str_b_q  <= '0;
         row_a_q  <= '0;
         row_b_q  <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         m_lim_q  <= '0;
         n_lim_q  <= '0;
         kw_lim_q <= '0;
         valid_q  <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (state_q == IDLE) begin
         if (start_i) begin
            base_b_q <= cfg_base_b_i;
            str_a_q  <= cfg_str_a_i;
            str_b_q  <= cfg_str_b_i;
            m_lim_q  <= cfg_m_i == '0 ? '0 : cfg_m_i - 1'b1;
            n_lim_q  <= cfg_n_i == '0 ? '0 : cfg_n_i - 1'b1;
            kw_lim_q <= kw_lim_d;
            row_a_q  <= cfg_base_a_i;
            row_b_q  <= cfg_base_b_i;
            addr_a_q <= cfg_base_a_i;
            addr_b_q <= cfg_base_b_i;
            first_q  <= 1'b1;
            last_q   <= kw_lim_d == '0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= RUN;
         end
      end else if (state_q == RUN) begin
         if (abort_i || final_beat) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= !abort_i;
            state_q <= abort_i ? IDLE : DONE;
         end else if (accept) begin
            row_a_q  <= row_a_d;
            row_b_q  <= row_b_d;
            addr_a_q <= row_a_d + ADDR_W'(k_nxt);
            addr_b_q <= row_b_d + ADDR_W'(k_nxt);
            first_q  <= k_wrap;
            last_q   <= k_nxt == kw_lim_q;
         end
      end else begin
         done_q  <= 1'b0;
         state_q <= IDLE;
      end
   end
endmodule

// File: tb/tb_tile_addr_seq.sv
// tb_tile_addr_seq: directed jobs push expected beats; a negedge monitor pops and compares accepted beats
module tb_tile_addr_seq;
   import tile_addr_seq_pkg::*;
   typedef struct packed {logic [31:0] a; logic [31:0] b; logic f; logic l;} beat_t;

   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic         busy, done;
   addrgen_cfg_t cfg = '0;
   beat_t        exp_q[$];
   beat_t        prev, cur, e;
   logic         prev_stall = 1'b0;
   int           tests = 0, fails = 0, accepted = 0, done_cnt = 0, negs = 0, last_acc = -10, d0 = 0;

   tile_addr_seq_if bus ();
   tile_addr_seq dut (
      .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
      .cfg_dtype_i(cfg.dtype), .cfg_base_a_i(cfg.base_a), .cfg_base_b_i(cfg.base_b),
      .cfg_str_a_i(cfg.str_a), .cfg_str_b_i(cfg.str_b),
      .cfg_m_i(cfg.m), .cfg_n_i(cfg.n), .cfg_k_i(cfg.k),
      .busy_o(busy), .done_o(done), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      negs++;
      cur = {bus.addr_a, bus.addr_b, bus.first_k, bus.last_k};
      if (rst) prev_stall = 1'b0;
      else begin
         if (bus.addr_valid && prev_stall) chk("stall_hold", cur, prev);
         if (bus.addr_valid) chk("busy_with_valid", busy, 1);
         if (bus.addr_valid && bus.addr_ready && !abort) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_beat: got a=%h b=%h, expected no beat", cur.a, cur.b);
            end else begin
               e = exp_q.pop_front();
               chk("addr_a", cur.a, e.a);
               chk("addr_b", cur.b, e.b);
               chk("first_k", cur.f, e.f);
               chk("last_k", cur.l, e.l);
            end
            accepted++;
            last_acc = negs;
         end
         if (done) begin
            chk("done_latency", negs, last_acc + 1);
            chk("busy_at_done", busy, 0);
            chk("valid_at_done", bus.addr_valid, 0);
            done_cnt++;
         end
         prev_stall = bus.addr_valid && !bus.addr_ready;
         prev = cur;
      end
   end

   function automatic addrgen_cfg_t mk(dtype_t dt, logic [31:0] ba, logic [31:0] bb, logic [31:0] sa,
                                       logic [31:0] sb, logic [7:0] m, logic [7:0] n, logic [11:0] k);
      addrgen_cfg_t c;
      c.dtype = dt; c.base_a = ba; c.base_b = bb; c.str_a = sa; c.str_b = sb; c.m = m; c.n = n; c.k = k;
      return c;
   endfunction

   task automatic push_beat(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l);
      exp_q.push_back({a, b, f, l});
   endtask

   task automatic push_model(input addrgen_cfg_t c);
      int m, n, k, pack, kw;
      m    = c.m == 0 ? 1 : int'(c.m);
      n    = c.n == 0 ? 1 : int'(c.n);
      k    = c.k == 0 ? 1 : int'(c.k);
      pack = c.dtype == FP32 ? 1 : c.dtype == FP16 ? 2 : c.dtype == INT8 ? 4 : 8;
      kw   = (k + pack - 1) / pack;
      for (int mt = 0; mt < m; mt++)
         for (int nt = 0; nt < n; nt++)
            for (int kk = 0; kk < kw; kk++)
               push_beat(c.base_a + 32'(mt) * c.str_a + 32'(kk), c.base_b + 32'(nt) * c.str_b + 32'(kk),
                         kk == 0, kk == kw - 1);
   endtask

   task automatic push_t1();
      push_beat('h100, 'h200, 1, 0); push_beat('h101, 'h201, 0, 0);
      push_beat('h102, 'h202, 0, 0); push_beat('h103, 'h203, 0, 1);
   endtask

   task automatic push_fp16();
      push_beat('h00, 'h00, 1, 0); push_beat('h01, 'h01, 0, 1);
      push_beat('h00, 'h20, 1, 0); push_beat('h01, 'h21, 0, 1);
      push_beat('h10, 'h00, 1, 0); push_beat('h11, 'h01, 0, 1);
      push_beat('h10, 'h20, 1, 0); push_beat('h11, 'h21, 0, 1);
   endtask

   task automatic start_job(input addrgen_cfg_t c);
      @(posedge clk); #1;
      cfg = c;
      accepted = 0;
      d0 = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int exp_n, input bit rnd);
      int t = 0;
      while (done_cnt == d0 && t < 3000) begin
         bus.addr_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
         @(posedge clk); #1;
         t++;
      end
      chk("done_seen", done_cnt != d0, 1);
      chk("beat_count", accepted, exp_n);
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      bus.addr_ready = 1'b1;
   endtask

   initial begin
      int t;
      bus.addr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.addr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_flags", {bus.first_k, bus.last_k}, 0);
      chk("rst_addr", {bus.addr_a, bus.addr_b}, 0);
      rst = 1'b0;

      push_t1();
      start_job(mk(FP32, 'h100, 'h200, 0, 0, 1, 1, 4));
      wait_done(4, 0);

      push_beat('h40, 'h80, 1, 0); push_beat('h41, 'h81, 0, 0); push_beat('h42, 'h82, 0, 1);
      start_job(mk(INT8, 'h40, 'h80, 0, 0, 1, 1, 10));
      wait_done(3, 0);

      push_beat('h0, 'h0, 1, 1); push_beat('h0, 'h10, 1, 1);
      start_job(mk(INT4, 0, 0, 0, 'h10, 1, 2, 8));
      wait_done(2, 0);

      push_fp16();
      start_job(mk(FP16, 0, 0, 'h10, 'h20, 2, 2, 4));
      wait_done(8, 0);

      push_model(mk(INT8, 'h1000, 'h2000, 'h100, 'h40, 3, 2, 9));
      start_job(mk(INT8, 'h1000, 'h2000, 'h100, 'h40, 3, 2, 9));
      wait_done(18, 1);

      push_beat('h55, 'h66, 1, 1);
      start_job(mk(FP32, 'h55, 'h66, 'h7, 'h9, 0, 0, 0));
      wait_done(1, 0);

      push_beat('hFFFF_FFFF, 'h0, 1, 0); push_beat('h0, 'h1, 0, 1);
      start_job(mk(FP32, 'hFFFF_FFFF, 0, 0, 0, 1, 1, 2));
      wait_done(2, 0);

      push_fp16();
      start_job(mk(FP16, 0, 0, 'h10, 'h20, 2, 2, 4));
      t = 0;
      while (accepted < 5 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("abort_reach_beat5", accepted, 5);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_valid", bus.addr_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_left", exp_q.size(), 3);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, d0);
      exp_q.delete();
      push_t1();
      start_job(mk(FP32, 'h100, 'h200, 0, 0, 1, 1, 4));
      wait_done(4, 0);

      bus.addr_ready = 1'b0;
      push_model(mk(FP32, 'h300, 'h400, 0, 0, 1, 1, 4));
      start_job(mk(FP32, 'h300, 'h400, 0, 0, 1, 1, 4));
      repeat (2) @(posedge clk);
      #1;
      cfg = mk(INT8, 'h900, 'hA00, 'h5, 'h5, 3, 3, 40);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(4, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("no_restart", bus.addr_valid, 0);

      push_model(mk(FP16, 0, 0, 'h10, 'h20, 2, 2, 4));
      start_job(mk(FP16, 0, 0, 'h10, 'h20, 2, 2, 4));
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_valid", bus.addr_valid, 0);
      chk("midrst_busy_done", {busy, done}, 0);
      chk("midrst_addr", {bus.addr_a, bus.addr_b}, 0);
      chk("midrst_flags", {bus.first_k, bus.last_k}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      push_t1();
      start_job(mk(FP32, 'h100, 'h200, 0, 0, 1, 1, 4));
      wait_done(4, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
